// File: rtl/jisuan_rounds_ff_pkg.sv
// Shared definitions for the ChaCha/Salsa round engine: word geometry, modes,
// lane-group index tables and the FSM state type.
package jisuan_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned NWORDS = 16;

    localparam logic MODE_CHACHA = 1'b0;
    localparam logic MODE_SALSA  = 1'b1;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [3:0]        idx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    // Each row is one lane's (a,b,c,d) word indices.
    localparam idx_t CHACHA_COL [4][4] = '{
        '{4'd0, 4'd4, 4'd8,  4'd12}, '{4'd1, 4'd5, 4'd9,  4'd13},
        '{4'd2, 4'd6, 4'd10, 4'd14}, '{4'd3, 4'd7, 4'd11, 4'd15}};
    localparam idx_t CHACHA_DIAG [4][4] = '{
        '{4'd0, 4'd5, 4'd10, 4'd15}, '{4'd1, 4'd6, 4'd11, 4'd12},
        '{4'd2, 4'd7, 4'd8,  4'd13}, '{4'd3, 4'd4, 4'd9,  4'd14}};
    localparam idx_t SALSA_COL [4][4] = '{
        '{4'd0,  4'd4,  4'd8, 4'd12}, '{4'd5,  4'd9,  4'd13, 4'd1},
        '{4'd10, 4'd14, 4'd2, 4'd6},  '{4'd15, 4'd3,  4'd7,  4'd11}};
    localparam idx_t SALSA_ROW [4][4] = '{
        '{4'd0,  4'd1,  4'd2,  4'd3},  '{4'd5,  4'd6,  4'd7,  4'd4},
        '{4'd10, 4'd11, 4'd8,  4'd9},  '{4'd15, 4'd12, 4'd13, 4'd14}};

    function automatic word_t rotl(input word_t x, input int unsigned n);
        return (x << n) | (x >> (WORD_W - n));
    endfunction

    function automatic idx_t lane_idx(input logic mode, input logic odd,
                                      input logic [1:0] lane, input logic [1:0] pos);
        idx_t r;
        case ({mode, odd})
            2'b00:   r = CHACHA_COL[lane][pos];
            2'b01:   r = CHACHA_DIAG[lane][pos];
            2'b10:   r = SALSA_COL[lane][pos];
            default: r = SALSA_ROW[lane][pos];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jisuan_rounds_ff_if.sv
// Request/response bundle between the state builder, the round engine and
// the keystream XOR stage.
interface jisuan_rounds_ff_if
    import jisuan_pkg::*;
#(
    parameter int unsigned MAX_DROUNDS = 10,
    parameter int unsigned DRW         = $clog2(MAX_DROUNDS + 1)
);
    logic                     in_vld;
    logic                     in_rdy;
    logic                     in_mode;
    logic [DRW-1:0]           in_drounds;
    logic [WORD_W*NWORDS-1:0] x_in;
    logic                     out_vld;
    logic                     out_rdy;
    logic                     out_mode;
    logic [WORD_W*NWORDS-1:0] x_out;
    logic                     busy;

    modport master (
        output in_vld, in_mode, in_drounds, x_in, out_rdy,
        input  in_rdy, out_vld, out_mode, x_out, busy
    );

    modport slave (
        input  in_vld, in_mode, in_drounds, x_in, out_rdy,
        output in_rdy, out_vld, out_mode, x_out, busy
    );
endinterface

// File: rtl/jisuan_quarter_dual.sv
// Combinational quarter round; mode_i selects the ChaCha or Salsa variant.
module jisuan_quarter_dual
    import jisuan_pkg::*;
(
    input  logic  mode_i,
    input  word_t a_i,
    input  word_t b_i,
    input  word_t c_i,
    input  word_t d_i,
    output word_t a_o,
    output word_t b_o,
    output word_t c_o,
    output word_t d_o
);
    word_t ca1, cb1, cc1, cd1, ca2, cb2, cc2, cd2;
    word_t sa, sb, sc, sd;

    assign ca1 = a_i + b_i;
    assign cd1 = rotl(d_i ^ ca1, 16);
    assign cc1 = c_i + cd1;
    assign cb1 = rotl(b_i ^ cc1, 12);
    assign ca2 = ca1 + cb1;
    assign cd2 = rotl(cd1 ^ ca2, 8);
    assign cc2 = cc1 + cd2;
    assign cb2 = rotl(cb1 ^ cc2, 7);

    assign sb = b_i ^ rotl(a_i + d_i, 7);
    assign sc = c_i ^ rotl(sb + a_i, 9);
    assign sd = d_i ^ rotl(sc + sb, 13);
    assign sa = a_i ^ rotl(sd + sc, 18);

    assign a_o = (mode_i == MODE_SALSA) ? sa : ca2;
    assign b_o = (mode_i == MODE_SALSA) ? sb : cb2;
    assign c_o = (mode_i == MODE_SALSA) ? sc : cc2;
    assign d_o = (mode_i == MODE_SALSA) ? sd : cd2;
endmodule

// File: rtl/jisuan_rounds_ff.sv
// ChaCha/Salsa permutation engine: one half-round per cycle through four
// shared dual-mode lanes, with optional feed-forward of the input state.
module jisuan_rounds_ff
    import jisuan_pkg::*;
#(
    parameter int unsigned MAX_DROUNDS = 10,
    parameter bit          FEED_FWD    = 1'b1,
    parameter int unsigned DRW         = $clog2(MAX_DROUNDS + 1)
)(
    input logic               clk,
    input logic               rst_n,
    jisuan_rounds_ff_if.slave bus
);
    localparam int unsigned    HCW  = $clog2(2 * MAX_DROUNDS);
    localparam logic [DRW-1:0] MAXD = DRW'(MAX_DROUNDS);

    state_e         state_q, state_d;
    logic [HCW-1:0] hc_q, hc_d, last_q, last_d;
    logic           mode_q, mode_d;
    word_t          st_q [NWORDS];
    word_t          st_d [NWORDS];
    word_t          orig_q [NWORDS];
    word_t          rnd [NWORDS];
    word_t          lane_in [4][4];
    word_t          lane_out [4][4];
    logic [DRW-1:0] n_eff;
    logic [DRW:0]   last_wide;
    logic           accept;

    assign bus.in_rdy   = (state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.out_rdy);
    assign accept       = bus.in_vld & bus.in_rdy;
    assign bus.out_vld  = (state_q == ST_DONE);
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.out_mode = mode_q;

    // Zero and out-of-range requests both run the full MAX_DROUNDS.
    assign n_eff     = ((bus.in_drounds == '0) || (bus.in_drounds > MAXD)) ? MAXD : bus.in_drounds;
    assign last_wide = {n_eff, 1'b0} - 1'b1;

    always_comb begin
        for (int unsigned l = 0; l < 4; l++)
            for (int unsigned p = 0; p < 4; p++)
                lane_in[l][p] = st_q[lane_idx(mode_q, hc_q[0], l[1:0], p[1:0])];
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        jisuan_quarter_dual u_qr (
            .mode_i (mode_q),
            .a_i    (lane_in[g][0]),
            .b_i    (lane_in[g][1]),
            .c_i    (lane_in[g][2]),
            .d_i    (lane_in[g][3]),
            .a_o    (lane_out[g][0]),
            .b_o    (lane_out[g][1]),
            .c_o    (lane_out[g][2]),
            .d_o    (lane_out[g][3])
        );
    end

    // Every word belongs to exactly one lane per half-round, so the scatter is a permutation.
    always_comb begin
        rnd = st_q;
        for (int unsigned l = 0; l < 4; l++)
            for (int unsigned p = 0; p < 4; p++)
                rnd[lane_idx(mode_q, hc_q[0], l[1:0], p[1:0])] = lane_out[l][p];
    end

    always_comb begin
        state_d = state_q;
        hc_d    = hc_q;
        last_d  = last_q;
        mode_d  = mode_q;
        unique case (state_q)
            ST_IDLE: ;
            ST_RUN: begin
                hc_d = hc_q + 1'b1;
                if (hc_q == last_q)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_rdy)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            state_d = ST_RUN;
            hc_d    = '0;
            last_d  = HCW'(last_wide);
            mode_d  = bus.in_mode;
        end
    end

    always_comb begin
        st_d = st_q;
        if (accept) begin
            for (int unsigned w = 0; w < NWORDS; w++)
                st_d[w] = bus.x_in[WORD_W*w +: WORD_W];
        end else if (state_q == ST_RUN) begin
            st_d = rnd;
        end
    end

    always_comb begin
        bus.x_out = '0;
        for (int unsigned w = 0; w < NWORDS; w++)
            bus.x_out[WORD_W*w +: WORD_W] = FEED_FWD ? (st_q[w] + orig_q[w]) : st_q[w];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hc_q    <= '0;
            last_q  <= '0;
            mode_q  <= MODE_CHACHA;
        end else begin
            state_q <= state_d;
            hc_q    <= hc_d;
            last_q  <= last_d;
            mode_q  <= mode_d;
        end
    end

    always_ff @(posedge clk) begin
        st_q <= st_d;
        if (accept) begin
            for (int unsigned w = 0; w < NWORDS; w++)
                orig_q[w] <= bus.x_in[WORD_W*w +: WORD_W];
        end
    end
endmodule

// File: tb/tb_jisuan_rounds_ff.sv
// Bench for jisuan_rounds_ff: feed-forward and raw builds side by side against
// a word-level ChaCha/Salsa reference, plus the standalone quarter round.
module tb_jisuan_rounds_ff;
    import jisuan_pkg::*;

    localparam int unsigned MAXD = 10;
    localparam int unsigned TDRW = $clog2(MAXD + 1);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    jisuan_rounds_ff_if #(.MAX_DROUNDS(MAXD)) bus_ff ();
    jisuan_rounds_ff_if #(.MAX_DROUNDS(MAXD)) bus_raw ();

    assign bus_raw.in_vld     = bus_ff.in_vld;
    assign bus_raw.in_mode    = bus_ff.in_mode;
    assign bus_raw.in_drounds = bus_ff.in_drounds;
    assign bus_raw.x_in       = bus_ff.x_in;
    assign bus_raw.out_rdy    = bus_ff.out_rdy;

    jisuan_rounds_ff #(.MAX_DROUNDS(MAXD), .FEED_FWD(1'b1)) u_dut (
        .clk (clk), .rst_n (rst_n), .bus (bus_ff));
    jisuan_rounds_ff #(.MAX_DROUNDS(MAXD), .FEED_FWD(1'b0)) u_dut_raw (
        .clk (clk), .rst_n (rst_n), .bus (bus_raw));

    logic  q_mode;
    word_t qa, qb, qc, qd, oa, ob, oc, od;
    jisuan_quarter_dual u_qr (
        .mode_i (q_mode), .a_i (qa), .b_i (qb), .c_i (qc), .d_i (qd),
        .a_o (oa), .b_o (ob), .c_o (oc), .d_o (od));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic word_t rl(input word_t x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] cqr(input word_t a, b, c, d);
        a = a + b; d = rl(d ^ a, 16);
        c = c + d; b = rl(b ^ c, 12);
        a = a + b; d = rl(d ^ a, 8);
        c = c + d; b = rl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    function automatic logic [127:0] sqr(input word_t a, b, c, d);
        b = b ^ rl(a + d, 7);
        c = c ^ rl(b + a, 9);
        d = d ^ rl(c + b, 13);
        a = a ^ rl(d + c, 18);
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] ap(input logic m, input logic [511:0] s,
                                        input int a, b, c, d);
        logic [127:0] q;
        q = m ? sqr(s[32*a +: 32], s[32*b +: 32], s[32*c +: 32], s[32*d +: 32])
              : cqr(s[32*a +: 32], s[32*b +: 32], s[32*c +: 32], s[32*d +: 32]);
        s[32*a +: 32] = q[127:96];
        s[32*b +: 32] = q[95:64];
        s[32*c +: 32] = q[63:32];
        s[32*d +: 32] = q[31:0];
        return s;
    endfunction

    function automatic logic [511:0] ref_blk(input logic m, input int n,
                                             input logic [511:0] x, input bit ff);
        logic [511:0] s;
        s = x;
        for (int r = 0; r < n; r++) begin
            if (!m) begin
                s = ap(0, s, 0, 4, 8, 12);  s = ap(0, s, 1, 5, 9, 13);
                s = ap(0, s, 2, 6, 10, 14); s = ap(0, s, 3, 7, 11, 15);
                s = ap(0, s, 0, 5, 10, 15); s = ap(0, s, 1, 6, 11, 12);
                s = ap(0, s, 2, 7, 8, 13);  s = ap(0, s, 3, 4, 9, 14);
            end else begin
                s = ap(1, s, 0, 4, 8, 12);  s = ap(1, s, 5, 9, 13, 1);
                s = ap(1, s, 10, 14, 2, 6); s = ap(1, s, 15, 3, 7, 11);
                s = ap(1, s, 0, 1, 2, 3);   s = ap(1, s, 5, 6, 7, 4);
                s = ap(1, s, 10, 11, 8, 9); s = ap(1, s, 15, 12, 13, 14);
            end
        end
        if (ff)
            for (int w = 0; w < 16; w++)
                s[32*w +: 32] = s[32*w +: 32] + x[32*w +: 32];
        return s;
    endfunction

    function automatic int eff_n(input int dr);
        return (dr == 0 || dr > int'(MAXD)) ? int'(MAXD) : dr;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int w = 0; w < 16; w++)
            v[32*w +: 32] = $urandom;
        return v;
    endfunction

    task automatic start_req(input logic m, input int dr, input logic [511:0] x);
        int g;
        @(negedge clk);
        bus_ff.in_vld     = 1'b1;
        bus_ff.in_mode    = m;
        bus_ff.in_drounds = TDRW'(dr);
        bus_ff.x_in       = x;
        g = 0;
        while (!bus_ff.in_rdy && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!bus_ff.in_rdy)
            chk("in_rdy_wait", {511'b0, bus_ff.in_rdy}, 512'd1);
        @(posedge clk);
        #1 bus_ff.in_vld = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!bus_ff.out_vld && lat < 200);
    endtask

    task automatic run_chk(input string tag, input logic m, input int dr,
                           input logic [511:0] x, output logic [511:0] res);
        int lat;
        start_req(m, dr, x);
        wait_out(lat);
        chk({tag, "_lat"}, 512'(lat), 512'(2 * eff_n(dr)));
        chk({tag, "_ff"}, bus_ff.x_out, ref_blk(m, eff_n(dr), x, 1'b1));
        chk({tag, "_raw"}, bus_raw.x_out, ref_blk(m, eff_n(dr), x, 1'b0));
        chk({tag, "_mode"}, {511'b0, bus_ff.out_mode}, {511'b0, m});
        res = bus_ff.x_out;
    endtask

    logic [511:0] x, r0, r1, snap;
    logic         m, snap_mode;
    int           lat, extra;

    initial begin
        rst_n = 1'b0;
        bus_ff.in_vld = 1'b0; bus_ff.in_mode = 1'b0; bus_ff.in_drounds = '0;
        bus_ff.x_in = '0; bus_ff.out_rdy = 1'b1;
        q_mode = 1'b0; qa = '0; qb = '0; qc = '0; qd = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_vld", {511'b0, bus_ff.out_vld}, 512'd0);
        chk("rst_in_rdy", {511'b0, bus_ff.in_rdy}, 512'd1);
        chk("rst_busy", {511'b0, bus_ff.busy}, 512'd0);
        chk("rst_out_mode", {511'b0, bus_ff.out_mode}, 512'd0);
        @(negedge clk) rst_n = 1'b1;

        q_mode = 1'b0; qa = 32'h11111111; qb = 32'h01020304; qc = 32'h9b8d6f43; qd = 32'h01234567;
        #1;
        chk("qr_c_a", 512'(oa), 512'h ea2a92f4); chk("qr_c_b", 512'(ob), 512'h cb1cf8ce);
        chk("qr_c_c", 512'(oc), 512'h 4581472e); chk("qr_c_d", 512'(od), 512'h 5881c4bb);
        q_mode = 1'b1; qa = 32'h00000001; qb = '0; qc = '0; qd = '0;
        #1;
        chk("qr_s_a", 512'(oa), 512'h 08008145); chk("qr_s_b", 512'(ob), 512'h 00000080);
        chk("qr_s_c", 512'(oc), 512'h 00010200); chk("qr_s_d", 512'(od), 512'h 20500000);

        x = {32'h00000000, 32'h4a000000, 32'h09000000, 32'h00000001,
             32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
             32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100,
             32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
        run_chk("rfc", 1'b0, 10, x, r0);
        chk("rfc_w0", 512'(r0[31:0]),   512'h e4e7f110);
        chk("rfc_w1", 512'(r0[63:32]),  512'h 15593bd1);
        chk("rfc_w2", 512'(r0[95:64]),  512'h 1fdd0f50);
        chk("rfc_w3", 512'(r0[127:96]), 512'h c47120a3);

        for (int i = 0; i < 16; i++)
            run_chk("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), rnd512(), r0);

        for (int mi = 0; mi < 2; mi++) begin
            x = rnd512();
            run_chk("clamp_max", 1'(mi), int'(MAXD), x, r0);
            run_chk("clamp_zero", 1'(mi), 0, x, r1);
            chk("clamp_zero_eq", r1, r0);
            run_chk("clamp_over", 1'(mi), int'(MAXD) + 3, x, r1);
            chk("clamp_over_eq", r1, r0);
            run_chk("zero_in", 1'(mi), int'($urandom_range(0, 13)), '0, r1);
            chk("zero_out", r1, '0);
        end

        // Salsa result held by backpressure, then same-edge handoff to ChaCha.
        x = rnd512();
        start_req(1'b1, 3, x);
        bus_ff.out_rdy = 1'b0;
        wait_out(lat);
        chk("b2b_lat1", 512'(lat), 512'd6);
        chk("b2b_res1", bus_ff.x_out, ref_blk(1'b1, 3, x, 1'b1));
        snap = bus_ff.x_out;
        snap_mode = bus_ff.out_mode;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("b2b_hold_x", bus_ff.x_out, snap);
            chk("b2b_hold_mode", {511'b0, bus_ff.out_mode}, {511'b0, snap_mode});
            chk("b2b_hold_vld", {511'b0, bus_ff.out_vld}, 512'd1);
            chk("b2b_hold_rdy", {511'b0, bus_ff.in_rdy}, 512'd0);
        end
        x = rnd512();
        @(negedge clk);
        bus_ff.in_vld = 1'b1; bus_ff.in_mode = 1'b0; bus_ff.in_drounds = TDRW'(2);
        bus_ff.x_in = x; bus_ff.out_rdy = 1'b1;
        #1 chk("b2b_in_rdy", {511'b0, bus_ff.in_rdy}, 512'd1);
        @(posedge clk);
        #1 bus_ff.in_vld = 1'b0;
        chk("b2b_handoff_vld", {511'b0, bus_ff.out_vld}, 512'd0);
        chk("b2b_handoff_busy", {511'b0, bus_ff.busy}, 512'd1);
        wait_out(lat);
        chk("b2b_lat2", 512'(lat), 512'd4);
        chk("b2b_mode2", {511'b0, bus_ff.out_mode}, 512'd0);
        chk("b2b_res2", bus_ff.x_out, ref_blk(1'b0, 2, x, 1'b1));
        chk("b2b_raw2", bus_raw.x_out, ref_blk(1'b0, 2, x, 1'b0));

        // Spurious requests while running must be ignored.
        x = rnd512();
        m = 1'($urandom_range(0, 1));
        start_req(m, 10, x);
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
            if (lat >= 2 && lat <= 8) begin
                bus_ff.in_vld  = 1'($urandom_range(0, 1));
                bus_ff.in_mode = 1'($urandom_range(0, 1));
                bus_ff.x_in    = rnd512();
            end else begin
                bus_ff.in_vld = 1'b0;
            end
        end while (!bus_ff.out_vld && lat < 200);
        chk("pulse_lat", 512'(lat), 512'd20);
        chk("pulse_res", bus_ff.x_out, ref_blk(m, 10, x, 1'b1));
        chk("pulse_mode", {511'b0, bus_ff.out_mode}, {511'b0, m});
        extra = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1 if (bus_ff.out_vld) extra++;
        end
        chk("pulse_extra", 512'(extra), 512'd0);
        chk("pulse_idle", {511'b0, bus_ff.busy}, 512'd0);

        // Asynchronous reset in the middle of a run.
        start_req(1'b1, 5, rnd512());
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_vld", {511'b0, bus_ff.out_vld}, 512'd0);
        chk("midrst_in_rdy", {511'b0, bus_ff.in_rdy}, 512'd1);
        chk("midrst_busy", {511'b0, bus_ff.busy}, 512'd0);
        @(negedge clk) rst_n = 1'b1;
        run_chk("post_rst", 1'b0, 7, rnd512(), r0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/jisuan_rounds_ff.md
# jisuan_rounds_ff

Parametrised ChaCha/Salsa permutation engine with per-request mode and round count, and optional feed-forward addition. It accepts a 16-word state over a valid/ready handshake and iterates one half-round (column, then diagonal or row) per cycle through four shared dual-mode quarter-round lanes. It returns either the permuted state or the finished keystream block (permuted state plus input state). It sits between the key/nonce/counter state builder and the keystream XOR stage, and is the successor to the fixed 10-double-round dual-pipe engine.

## Interface
- MAX_DROUNDS, 10: maximum double rounds per request (≥1).
- FEED_FWD, 1: 1 = output is per-word (state + input) mod 2^32; 0 = raw permuted state.
- DRW, $clog2(MAX_DROUNDS+1): derived width of in_drounds; not to be overridden.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_vld  in  1  request valid.
- in_rdy  out  1  engine can accept.
- in_mode  in  1  0 = ChaCha, 1 = Salsa.
- in_drounds  in  DRW  double rounds requested.
- x_in  in  512  input state; word i at [32*i+:32].
- out_vld  out  1  result valid.
- out_rdy  in  1  downstream accepts.
- out_mode  out  1  mode of the current result.
- x_out  out  512  result; word i at [32*i+:32].
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_rdy=1. On in_vld&in_rdy, latch x_in into st and orig, latch mode, latch the half-round target, clear the half-round counter hc, go to RUN.
- Target = 2*N, where:
  - N = in_drounds if 1 ≤ in_drounds ≤ MAX_DROUNDS;
  - in_drounds = 0 gives N = MAX_DROUNDS;
  - in_drounds > MAX_DROUNDS clamps to MAX_DROUNDS.
- RUN: each cycle st <= half-round(st) and hc <= hc+1.
  - Even hc applies the column round; odd hc applies the diagonal (ChaCha) or row (Salsa) round.
  - When hc reaches target-1, go to DONE.
- ChaCha lane groups (a,b,c,d):
  - column: (0,4,8,12) (1,5,9,13) (2,6,10,14) (3,7,11,15)
  - diagonal: (0,5,10,15) (1,6,11,12) (2,7,8,13) (3,4,9,14)
- ChaCha QR: a+=b; d^=a; d<<<=16; c+=d; b^=c; b<<<=12; a+=b; d^=a; d<<<=8; c+=d; b^=c; b<<<=7.
- Salsa lane groups:
  - column: (0,4,8,12) (5,9,13,1) (10,14,2,6) (15,3,7,11)
  - row: (0,1,2,3) (5,6,7,4) (10,11,8,9) (15,12,13,14)
- Salsa QR: b^=(a+d)<<<7; c^=(b+a)<<<9; d^=(c+b)<<<13; a^=(d+c)<<<18.
- All additions are mod 2^32, with no carry out of a word.
- DONE:
  - out_vld=1; x_out = FEED_FWD ? st+orig (per word) : st; out_mode = latched mode.
  - x_out and out_mode hold stable until out_vld&out_rdy.
  - On that handshake: if in_vld is also high, accept the new request in the same edge and go to RUN (in_rdy = IDLE | (DONE & out_rdy)); otherwise go to IDLE.
- in_vld during RUN is ignored and not captured.
- Reset values: FSM IDLE, hc 0, out_vld 0, in_rdy 1, busy 0, out_mode 0. st and orig are not reset; x_out is don't-care while out_vld=0.
- Reset asserted mid-RUN or mid-DONE aborts the request; no partial output is ever presented.

## Timing
- Accept at edge t0. Half-rounds occur at edges t0+1 … t0+2N. out_vld rises after edge t0+2N.
- Latency is 2N cycles from accept to out_vld; 2N+1 cycles per block at full throughput with back-to-back handshakes.
- ChaCha N=10 gives 20 cycles; MAX_DROUNDS=10 with in_drounds=4 gives 8 cycles.
- The critical path is one quarter round plus the 2:1 lane mux; the feed-forward adder is combinational from st/orig in DONE.
- out_rdy held low keeps the engine in DONE indefinitely; in_rdy=0 until released.

## Structure
- Shared package jisuan_pkg holds:
  - MODE_CHACHA/MODE_SALSA constants;
  - the state-word width (32) and word count (16);
  - the two lane-group index tables (column/diag for ChaCha, column/row for Salsa);
  - the FSM state enum.
- Sub-module jisuan_quarter_dual: a combinational quarter round with a mode input selecting the ChaCha or Salsa QR; instantiated four times.
- The top level holds the FSM, counter, lane gather/scatter muxes and feed-forward adders.

## Test plan
- Reset: assert rst_n low mid-RUN -> out_vld=0, in_rdy=1, busy=0 immediately; the next request completes correctly.
- ChaCha block (RFC 8439 §2.3.2 state: constants 61707865 3320646e 79622d32 6b206574, key 03020100…1f1e1d1c, counter 00000001, nonce 09000000 4a000000 00000000), in_drounds=10, FEED_FWD=1 -> x_out words 0..3 = e4e7f110 15593bd1 1fdd0f50 c47120a3; out_vld exactly 20 cycles after accept.
- Quarter round: jisuan_quarter_dual ChaCha (11111111, 01020304, 9b8d6f43, 01234567) -> (ea2a92f4, cb1cf8ce, 4581472e, 5881c4bb). Salsa (00000001, 0, 0, 0) -> (08008145, 00000080, 00010200, 20500000).
- Round clamp: in_drounds=0 and in_drounds=MAX_DROUNDS+3 -> latency 2*MAX_DROUNDS and output identical to the in_drounds=MAX_DROUNDS run. All-zero x_in in both modes -> all-zero x_out.
- Back-to-back: Salsa request held behind out_rdy=0 for 5 cycles -> x_out/out_mode stable; on release with a ChaCha request pending -> same-edge handoff, second result 2N cycles later with out_mode=0.
- Backpressure: in_vld pulses during RUN -> ignored, exactly one output produced; FEED_FWD=0 build -> x_out equals the raw permuted state from a software model.
